// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state codes,
// default sizing constants and a modular index increment helper.
package rr_mux_arbiter_pkg;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate candidates so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic          any,
    output logic [IW-1:0] win_idx
);

    logic [N-1:0] cand;
    logic [N-1:0] rot;
    logic [IW:0]  off;
    logic [IW:0]  sum;

    assign cand = req & ~mask;
    assign rot  = N'({cand, cand} >> ptr);
    assign any  = |rot;

    // Walking downward leaves the lowest set bit as the final assignment.
    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = (IW + 1)'(i);
            end
        end
    end

    assign sum     = {1'b0, ptr} + off;
    assign win_idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : IW'(sum);

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one N-to-1 data mux. Optional grant hold limit
// with preemption is enabled by defining ARB_HOLD_LIMIT_EN.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int IW       = 2,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] w,
    output logic [N-1:0]   gnt,
    output logic [IW-1:0]  gnt_idx,
    output logic           busy,
    output logic [W-1:0]   f
);

    generate
        if (N < 2 || N > 16 || IW != $clog2(N) || MAX_HOLD < 1) begin : g_param_err
            $error("rr_mux_arbiter: illegal N/IW/MAX_HOLD combination");
        end
    endgenerate

    arb_state_t    state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [N-1:0]  gnt_reg, gnt_next;
    logic [IW-1:0] idx_inc, pick_ptr, win_idx;
    logic [N-1:0]  win_onehot;
    logic          any, owner_req, hold_expired;

    assign busy      = (state_reg == ST_GRANT);
    assign idx_inc   = IW'(wrap_inc(int'(idx_reg), N));
    // While granted, search starts just past the owner so it ranks last.
    assign pick_ptr  = busy ? idx_inc : ptr_reg;
    assign owner_req = |(req & gnt_reg);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .mask    (gnt_reg),
        .any     (any),
        .win_idx (win_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any) begin
                    state_next = ST_GRANT;
                    idx_next   = win_idx;
                    gnt_next   = win_onehot;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    ptr_next = idx_inc;
                    if (any) begin
                        idx_next = win_idx;
                        gnt_next = win_onehot;
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                    end
                end else if (hold_expired && any) begin
                    ptr_next = idx_inc;
                    idx_next = win_idx;
                    gnt_next = win_onehot;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_reg, hold_next;

    assign hold_expired = (hold_reg == HW'(MAX_HOLD - 1));

    // Counts only while the same owner keeps the grant; saturates at the limit.
    always_comb begin
        hold_next = '0;
        if (state_reg == ST_GRANT && state_next == ST_GRANT && idx_next == idx_reg) begin
            hold_next = hold_expired ? hold_reg : hold_reg + HW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign gnt     = gnt_reg;
    assign gnt_idx = idx_reg;

    always_comb begin
        f = '0;
        if (busy) begin
            f = w[idx_reg*W +: W];
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed plus randomized bench for rr_mux_arbiter against an index-level
// round-robin reference model; build with ARB_HOLD_LIMIT_EN to cover preemption.
module tb_rr_mux_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int IW       = 2;
    localparam int MAX_HOLD = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] w;
    logic [N-1:0]   gnt;
    logic [IW-1:0]  gnt_idx;
    logic           busy;
    logic [W-1:0]   f;

    int vectors     = 0;
    int miscompares = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    always #5 clock = ~clock;

    rr_mux_arbiter #(
        .N        (N),
        .W        (W),
        .IW       (IW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .w       (w),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .f       (f)
    );

    function automatic int rr_search(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int win;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            win = rr_search(req, m_ptr, -1);
            if (win >= 0) begin
                m_owner = win;
                m_hold  = 0;
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = rr_search(req, m_ptr, -1);
            m_hold  = 0;
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            win = rr_search(req, (m_owner + 1) % N, m_owner);
            if (m_hold == MAX_HOLD - 1 && win >= 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = win;
                m_hold  = 0;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r_rst, input logic [N-1:0] r_req);
        logic [31:0] exp_gnt, exp_f;
        @(negedge clock);
        reset = r_rst;
        req   = r_req;
        @(posedge clock);
        model_edge();
        #1;
        exp_gnt = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        exp_f   = (m_owner < 0) ? 32'd0 : ((w >> (m_owner * W)) & 32'hFF);
        chk("model_gnt", 32'(gnt), exp_gnt);
        chk("model_busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        chk("model_f", 32'(f), exp_f);
        if (m_owner >= 0) chk("model_idx", 32'(gnt_idx), 32'(m_owner));
        $display("cyc rst=%b req=%b gnt=%b idx=%0d busy=%b f=%h", r_rst, r_req, gnt, gnt_idx, busy, f);
    endtask

    initial begin
        int c;
        logic [N-1:0] m;
        logic [N-1:0] r;
        logic [N-1:0] prev;

        reset = 1'b1;
        req   = 4'b1111;
        w     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        // Reset with all requests high
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);

        step(1'b0, 4'b1111);
        chk("first_gnt", 32'(gnt), 32'b0001);
        chk("first_idx", 32'(gnt_idx), 32'd0);

        // Rotation 0,1,2,3,0 with one-cycle release per owner
        for (int k = 0; k < 5; k++) begin
            chk("rot_owner", 32'(gnt_idx), 32'(k % 4));
            chk("rot_busy", 32'(busy), 32'd1);
            step(1'b0, 4'b1111);
            m = 4'b0001 << (k % 4);
            step(1'b0, ~m);
            chk("rot_nobubble", 32'(busy), 32'd1);
        end

        // Wrap and skip from ptr=3
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0101);
        chk("wrap_gnt0", 32'(gnt), 32'b0001);
        chk("wrap_f0", 32'(f), 32'hA0);
        step(1'b0, 4'b0100);
        chk("wrap_gnt2", 32'(gnt), 32'b0100);
        chk("wrap_f2", 32'(f), 32'hC2);
        step(1'b0, 4'b0000);

        // Single requester holds indefinitely
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0100);
            chk("single_gnt", 32'(gnt), 32'b0100);
        end
        step(1'b0, 4'b0000);
        chk("single_idle", 32'(busy), 32'd0);
        chk("single_f0", 32'(f), 32'd0);

        // Hold limit / preemption
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        chk("pre_gnt1", 32'(gnt), 32'b0010);
        c = 1;
        step(1'b0, 4'b0010);
        if (gnt == 4'b0010) c++;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 4'b1010);
            if (gnt == 4'b0010) c++;
            else break;
        end
`ifdef ARB_HOLD_LIMIT_EN
        chk("pre_hold_cycles", 32'(c), 32'd8);
        chk("pre_gnt3", 32'(gnt), 32'b1000);
`else
        chk("nopre_hold_cycles", 32'(c), 32'd17);
        step(1'b0, 4'b1000);
        chk("nopre_gnt3", 32'(gnt), 32'b1000);
`endif
        step(1'b0, 4'b0000);

        // Reset mid-grant
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0100);
        chk("mid_gnt2", 32'(gnt), 32'b0100);
        step(1'b1, 4'b0100);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step(1'b0, 4'b0110);
        chk("mid_next_gnt1", 32'(gnt), 32'b0010);
        step(1'b0, 4'b0000);

        // Randomized traffic, mostly level-held requests
        prev = '0;
        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r = prev;
            prev = r;
            step(($urandom_range(0, 49) == 0), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
